// File: rtl/result_accumulator_pkg.sv
// Shared types and constants for the result accumulator and its saturating adder.
package result_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    localparam int RES_W         = 5;
    localparam int CNT_W         = 5;
    localparam int BATCH_DEFAULT = 8;
    localparam int ACC_W_DEFAULT = 8;

endpackage

// File: rtl/result_accumulator_sat_add.sv
// Saturating adder: ACC_W-wide accumulator plus a zero-extended RES_W-bit operand.
module sat_add
    import result_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [RES_W-1:0] operand_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] wide_sum;

    // One guard bit is enough because ACC_W is never narrower than the operand.
    always_comb begin
        wide_sum = {1'b0, acc_i} + (ACC_W+1)'(operand_i);
        ovf_o    = wide_sum[ACC_W];
        sum_o    = ovf_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/result_accumulator.sv
// Batches upstream 5-bit results into a saturating total, emitted with a valid/ready handshake.
// state | meaning
// ACCUM | accepting beats (ready_o=1), total not yet presented
// HOLD  | total presented on sum_o/count_o/sat_o (valid_o=1) until ready_i
module result_accumulator
    import result_accumulator_pkg::*;
#(
    parameter int BATCH = BATCH_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [RES_W-1:0] result_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             flush_i,
    output logic [ACC_W-1:0] sum_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .acc_i     (acc_q),
        .operand_i (result_i),
        .sum_o     (add_sum),
        .ovf_o     (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        accept  = (state_q == ACCUM) && valid_i;
        cnt_inc = cnt_q + CNT_W'(1);

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    sat_d = sat_q | add_ovf;
                end
                // A flush with nothing held and nothing arriving has no total to emit.
                if ((accept && (cnt_inc == BATCH_C)) ||
                    (flush_i && ((cnt_q != '0) || accept))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // The running accumulator doubles as the output register; it is frozen throughout HOLD.
    assign ready_o = (state_q == ACCUM);
    assign valid_o = (state_q == HOLD);
    assign sum_o   = acc_q;
    assign count_o = cnt_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Scoreboard bench: expected totals queued at stimulus time, popped by a monitor on each output handshake.
module tb_result_accumulator;

    typedef struct {
        int sum;
        int cnt;
        int sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;

    logic [4:0] result_a = '0;
    logic       valid_a = 1'b0;
    logic       flush_a = 1'b0;
    logic       ready_a = 1'b1;
    logic       ready_o_a, sat_o_a, valid_o_a;
    logic [7:0] sum_o_a;
    logic [4:0] count_o_a;

    logic [4:0] result_b = '0;
    logic       valid_b = 1'b0;
    logic       flush_b = 1'b0;
    logic       ready_b = 1'b1;
    logic       ready_o_b, sat_o_b, valid_o_b;
    logic [7:0] sum_o_b;
    logic [4:0] count_o_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    result_accumulator dut_a (
        .clk_i(clk), .reset_i(reset_i), .result_i(result_a), .valid_i(valid_a),
        .ready_o(ready_o_a), .flush_i(flush_a), .sum_o(sum_o_a), .count_o(count_o_a),
        .sat_o(sat_o_a), .valid_o(valid_o_a), .ready_i(ready_a)
    );

    result_accumulator #(.BATCH(16), .ACC_W(8)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .result_i(result_b), .valid_i(valid_b),
        .ready_o(ready_o_b), .flush_i(flush_b), .sum_o(sum_o_b), .count_o(count_o_b),
        .sat_o(sat_o_b), .valid_o(valid_o_b), .ready_i(ready_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs sampled on the falling edge; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (mon_en && !reset_i) begin
            if (valid_o_a && ready_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("a_sum", 32'(sum_o_a), 32'(e.sum));
                    check("a_count", 32'(count_o_a), 32'(e.cnt));
                    check("a_sat", 32'(sat_o_a), 32'(e.sat));
                end
            end
            if (valid_o_b && ready_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("b_sum", 32'(sum_o_b), 32'(e.sum));
                    check("b_count", 32'(count_o_b), 32'(e.cnt));
                    check("b_sat", 32'(sat_o_b), 32'(e.sat));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats_a(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            result_a = 5'(v);
            valid_a  = 1'b1;
            tick();
        end
        valid_a = 1'b0;
    endtask

    task automatic beats_b(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            result_b = 5'(v);
            valid_b  = 1'b1;
            tick();
        end
        valid_b = 1'b0;
    endtask

    task automatic push_a(input int s, input int c, input int t);
        exp_t e;
        e.sum = s; e.cnt = c; e.sat = t;
        q_a.push_back(e);
    endtask

    initial begin
        exp_t eb;
        int   budget;

        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        check("rst_ready", 32'(ready_o_a), 32'd1);
        check("rst_valid", 32'(valid_o_a), 32'd0);
        check("rst_sum", 32'(sum_o_a), 32'd0);
        check("rst_count", 32'(count_o_a), 32'd0);
        check("rst_sat", 32'(sat_o_a), 32'd0);
        mon_en = 1'b1;

        // 8 beats of 5
        push_a(40, 8, 0);
        beats_a(7, 5);
        check("b7_valid_low", 32'(valid_o_a), 32'd0);
        beats_a(1, 5);
        check("latency_valid", 32'(valid_o_a), 32'd1);
        check("latency_ready_low", 32'(ready_o_a), 32'd0);
        tick();
        check("release_ready", 32'(ready_o_a), 32'd1);
        check("release_valid", 32'(valid_o_a), 32'd0);

        // 8 beats of 31 stays under 255
        push_a(248, 8, 0);
        beats_a(8, 31);
        check("max_nosat_valid", 32'(valid_o_a), 32'd1);
        tick();

        // BATCH=16: 16 beats of 31 clamps at 255
        eb.sum = 255; eb.cnt = 16; eb.sat = 1;
        q_b.push_back(eb);
        beats_b(15, 31);
        check("b16_valid_low", 32'(valid_o_b), 32'd0);
        beats_b(1, 31);
        check("b16_valid", 32'(valid_o_b), 32'd1);
        tick();

        // flush together with the 4th beat
        push_a(10, 4, 0);
        beats_a(1, 1);
        beats_a(1, 2);
        beats_a(1, 3);
        result_a = 5'd4;
        valid_a  = 1'b1;
        flush_a  = 1'b1;
        tick();
        valid_a = 1'b0;
        flush_a = 1'b0;
        check("flush_valid", 32'(valid_o_a), 32'd1);
        tick();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        check("empty_flush_valid", 32'(valid_o_a), 32'd0);
        check("empty_flush_ready", 32'(ready_o_a), 32'd1);

        // back-pressure: HOLD for 5 cycles with beats and flush offered
        ready_a = 1'b0;
        push_a(16, 8, 0);
        beats_a(8, 2);
        for (int i = 0; i < 5; i++) begin
            result_a = 5'd7;
            valid_a  = 1'b1;
            flush_a  = 1'b1;
            tick();
            check("hold_valid", 32'(valid_o_a), 32'd1);
            check("hold_ready", 32'(ready_o_a), 32'd0);
            check("hold_sum", 32'(sum_o_a), 32'd16);
            check("hold_count", 32'(count_o_a), 32'd8);
        end
        valid_a = 1'b0;
        flush_a = 1'b0;
        ready_a = 1'b1;
        tick();
        check("hold_release_ready", 32'(ready_o_a), 32'd1);
        push_a(8, 8, 0);
        beats_a(8, 1);
        tick();

        // reset mid-batch, with a beat offered on the reset edge
        beats_a(5, 3);
        reset_i  = 1'b1;
        result_a = 5'd3;
        valid_a  = 1'b1;
        tick();
        reset_i = 1'b0;
        valid_a = 1'b0;
        check("midrst_valid", 32'(valid_o_a), 32'd0);
        check("midrst_ready", 32'(ready_o_a), 32'd1);
        check("midrst_count", 32'(count_o_a), 32'd0);
        check("midrst_sum", 32'(sum_o_a), 32'd0);

        // reset during HOLD discards the pending total
        ready_a = 1'b0;
        beats_a(8, 9);
        check("pre_rst_hold_valid", 32'(valid_o_a), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("holdrst_valid", 32'(valid_o_a), 32'd0);
        check("holdrst_ready", 32'(ready_o_a), 32'd1);
        check("holdrst_sum", 32'(sum_o_a), 32'd0);
        ready_a = 1'b1;
        push_a(8, 8, 0);
        beats_a(8, 1);
        tick();

        budget = 20;
        while ((q_a.size() != 0 || q_b.size() != 0) && budget > 0) begin
            tick();
            budget--;
        end
        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 Parameter BATCH, default 8, SHALL set the number of accepted beats per emitted total; legal range 2..16.
REQ-002 Parameter ACC_W, default 8, SHALL set the width of the accumulated total; legal range 5..12.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  SHALL be the synchronous, active-high reset.
REQ-005 result_i  input  5  SHALL carry the unsigned 5-bit sum from the upstream adder stage.
REQ-006 valid_i  input  1  SHALL qualify result_i.
REQ-007 ready_o  output  1  SHALL indicate this block can accept a beat.
REQ-008 flush_i  input  1  SHALL request early emission of a partial batch.
REQ-009 sum_o  output  ACC_W  SHALL carry the emitted total.
REQ-010 count_o  output  5  SHALL carry the number of beats contained in sum_o.
REQ-011 sat_o  output  1  SHALL flag that sum_o saturated.
REQ-012 valid_o  output  1  SHALL qualify sum_o, count_o and sat_o.
REQ-013 ready_i  input  1  SHALL indicate the downstream consumer takes the output.

Function
REQ-014 A beat SHALL be accepted on a rising edge where valid_i and ready_o are both 1.
REQ-015 The FSM SHALL have two states: ACCUM (ready_o=1, valid_o=0) and HOLD (ready_o=0, valid_o=1).
REQ-016 In ACCUM, each accepted beat SHALL add zero-extended result_i to the accumulator and increment the beat counter.
REQ-017 Accumulation SHALL saturate at 2^ACC_W-1; any addition that would exceed it SHALL clamp and set a sticky saturation bit for the batch.
REQ-018 When the accepted beat is the BATCH-th, the FSM SHALL enter HOLD on the same edge with sum_o, count_o=BATCH and sat_o registered, so valid_o is high in the next cycle (latency 1 edge from last beat).
REQ-019 flush_i high in ACCUM with at least one beat held, or with a beat accepted that cycle, SHALL enter HOLD on that edge; an accepted beat in that cycle SHALL be included in the total.
REQ-020 flush_i in ACCUM with zero beats held and no beat accepted SHALL be ignored.
REQ-021 flush_i in HOLD SHALL be ignored.
REQ-022 In HOLD, sum_o, count_o and sat_o SHALL remain stable until the edge where ready_i=1.
REQ-023 On the HOLD edge with ready_i=1, the FSM SHALL return to ACCUM with accumulator, counter and saturation bit cleared; no beat is accepted on that edge (ready_o=0).
REQ-024 valid_i while ready_o=0 SHALL be ignored; the upstream holds the beat.

Reset
REQ-025 With reset_i=1 at a rising edge, the FSM SHALL enter ACCUM and clear the accumulator, counter and saturation bit.
REQ-026 After reset, outputs SHALL be: ready_o=1, valid_o=0, sum_o=0, count_o=0, sat_o=0.
REQ-027 Reset SHALL take priority over acceptance, flush and handshake in the same cycle, including mid-batch and in HOLD; the pending total is discarded.

Structure
REQ-028 A shared package SHALL hold the state enumeration (ACCUM, HOLD), the 5-bit input width constant, and the BATCH/ACC_W defaults.
REQ-029 The saturating add SHALL be a sub-module named sat_add (ACC_W-wide accumulator plus 5-bit operand, clamp output and overflow flag).

Verification
REQ-030 Reset then 8 beats of 5 with ready_i=1 -> one cycle after the 8th accept: valid_o=1, sum_o=40, count_o=8, sat_o=0; ready_o=1 one cycle later.
REQ-031 8 beats of 31 (ACC_W=8) -> sum_o=248, sat_o=0; with BATCH=16, 16 beats of 31 -> sum_o=255, count_o=16, sat_o=1.
REQ-032 3 beats (1,2,3), then flush_i with 4th beat 4 in same cycle -> sum_o=10, count_o=4; flush_i alone with zero beats -> no valid_o.
REQ-033 Batch complete with ready_i=0 for 5 cycles -> valid_o stays 1, sum_o stable, ready_o=0, valid_i beats during HOLD not counted.
REQ-034 reset_i asserted after 5 of 8 beats and again during HOLD -> next cycle valid_o=0, ready_o=1, following 8 beats of 1 give sum_o=8.
